exec_stage: RTL and testbench

- Execute stage of the 5-stage MIPS64 pipeline: a 64-bit ALU, a 32-bit branch-target adder and the E->M pipeline register.
- Sits between the D->E register/forwarding muxes and the memory stage.
- The ALU result, store data and destination register are captured on each clock edge for stage M.
- The zero flag and branch target are combinational.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/exec_stage_if.sv | 43 ++++
 rtl/exec_alu.sv | 54 +++++
 rtl/exec_stage.sv | 61 ++++++
 tb/tb_exec_stage.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS64 execute stage.
//   - alu_op_t     : 4-bit ALU operation select
//   - ALU_*        : opcode constants for the execute-stage ALU
//   - MIPS_N/W/R   : default datapath, PC and register-index widths
package mips_pkg;

  localparam int MIPS_N = 64;  // datapath / ALU width
  localparam int MIPS_W = 32;  // PC / branch-adder width
  localparam int MIPS_R = 5;   // register-index width

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND   = 4'b0000;
  localparam alu_op_t ALU_OR    = 4'b0001;
  localparam alu_op_t ALU_ADD   = 4'b0010;
  localparam alu_op_t ALU_XOR   = 4'b0011;
  localparam alu_op_t ALU_NOR   = 4'b0100;
  localparam alu_op_t ALU_SLL   = 4'b0101;
  localparam alu_op_t ALU_SUB   = 4'b0110;
  localparam alu_op_t ALU_SLT   = 4'b0111;
  localparam alu_op_t ALU_SLTU  = 4'b1000;
  localparam alu_op_t ALU_SRL   = 4'b1001;
  localparam alu_op_t ALU_ADD32 = 4'b1010;
  localparam alu_op_t ALU_SRA   = 4'b1011;
  localparam alu_op_t ALU_SUB32 = 4'b1110;
  localparam alu_op_t ALU_PASSB = 4'b1111;
  // 4'b1100 and 4'b1101 are unassigned and produce a zero result.

endpackage

// File: rtl/exec_stage_if.sv
// exec_stage_if: signal bundle between the D->E forwarding muxes, the
// execute stage and the memory stage.
//   E-side inputs : srcaE, srcbE, alucontrolE, writedataE, writeregE, pcE, offE
//   Combinational : pcbranch, zero, aluoutE
//   M-side outputs: aluoutM, writedataM, writeregM
// Modports:
//   master - the surrounding pipeline (drives E inputs, observes outputs)
//   slave  - the execute stage itself
interface exec_stage_if
  import mips_pkg::*;
#(
  parameter int N = MIPS_N,
  parameter int W = MIPS_W,
  parameter int R = MIPS_R
);

  logic [N-1:0] srcaE;
  logic [N-1:0] srcbE;
  alu_op_t      alucontrolE;
  logic [N-1:0] writedataE;
  logic [R-1:0] writeregE;
  logic [W-1:0] pcE;
  logic [W-1:0] offE;

  logic [W-1:0] pcbranch;
  logic         zero;
  logic [N-1:0] aluoutE;

  logic [N-1:0] aluoutM;
  logic [N-1:0] writedataM;
  logic [R-1:0] writeregM;

  modport master (
    output srcaE, srcbE, alucontrolE, writedataE, writeregE, pcE, offE,
    input  pcbranch, zero, aluoutE, aluoutM, writedataM, writeregM
  );

  modport slave (
    input  srcaE, srcbE, alucontrolE, writedataE, writeregE, pcE, offE,
    output pcbranch, zero, aluoutE, aluoutM, writedataM, writeregM
  );

endinterface

// File: rtl/exec_alu.sv
// exec_alu: purely combinational N-bit MIPS64 ALU.
//   a, b : operands (shift amount comes from a, shifted value is b)
//   op   : operation select (alu_op_t)
//   y    : result; arithmetic wraps, no overflow detection
//   zero : 1 when y is all zeros
module exec_alu
  import mips_pkg::*;
#(
  parameter int N = MIPS_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_op_t      op,
  output logic [N-1:0] y,
  output logic         zero
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] shamt;
  logic [31:0]   sum32;
  logic [31:0]   diff32;

  assign shamt  = a[SW-1:0];
  assign sum32  = a[31:0] + b[31:0];
  assign diff32 = a[31:0] - b[31:0];

  always_comb begin
    // NOTE: y gets a default before the case so every path assigns it and
    // no latch is inferred; undefined opcodes fall through to this zero.
    y = '0;
    unique case (op)
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_ADD:   y = a + b;
      ALU_XOR:   y = a ^ b;
      ALU_NOR:   y = ~(a | b);
      ALU_SLL:   y = b << shamt;
      ALU_SUB:   y = a - b;
      ALU_SLT:   y = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  y = {{(N-1){1'b0}}, (a < b)};
      ALU_SRL:   y = b >> shamt;
      // 32-bit word ops: compute in the low word, then sign-extend.
      ALU_ADD32: y = {{(N-32){sum32[31]}}, sum32};
      ALU_SRA:   y = $signed(b) >>> shamt;
      ALU_SUB32: y = {{(N-32){diff32[31]}}, diff32};
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end

  assign zero = ~|y;

endmodule

// File: rtl/exec_stage.sv
// exec_stage: execute stage of the 5-stage MIPS64 pipeline.
//   clk   : pipeline clock, rising edge
//   reset : synchronous, active-high; clears the E->M register to a NOP
//           bubble (result 0, store data 0, destination $0)
//   bus   : exec_stage_if.slave
//           - ALU on srcaE/srcbE/alucontrolE -> aluoutE, zero (combinational)
//           - branch adder pcE + offE -> pcbranch (combinational, wraps)
//           - E->M register -> aluoutM, writedataM, writeregM (1-cycle latency)
module exec_stage
  import mips_pkg::*;
#(
  parameter int N = MIPS_N,
  parameter int W = MIPS_W,
  parameter int R = MIPS_R
) (
  input  logic         clk,
  input  logic         reset,
  exec_stage_if.slave  bus
);

  logic [N-1:0] alu_y;
  logic         alu_zero;

  exec_alu #(.N(N)) u_alu (
    .a    (bus.srcaE),
    .b    (bus.srcbE),
    .op   (bus.alucontrolE),
    .y    (alu_y),
    .zero (alu_zero)
  );

  assign bus.aluoutE = alu_y;
  assign bus.zero    = alu_zero;

  // Carry out of the W-bit sum is dropped on purpose: branch targets wrap.
  assign bus.pcbranch = bus.pcE + bus.offE;

  logic [N-1:0] aluout_q;
  logic [N-1:0] writedata_q;
  logic [R-1:0] writereg_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is synchronous, so before the first
    // reset edge these registers are simply undefined.
    if (reset) begin
      aluout_q    <= '0;
      writedata_q <= '0;
      writereg_q  <= '0;
    end else begin
      aluout_q    <= alu_y;
      writedata_q <= bus.writedataE;
      writereg_q  <= bus.writeregE;
    end
  end

  assign bus.aluoutM    = aluout_q;
  assign bus.writedataM = writedata_q;
  assign bus.writeregM  = writereg_q;

endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed, self-checking bench for exec_stage.
// Inputs are driven on the falling edge; combinational outputs are checked
// right after driving, registered outputs #1 after the rising edge against a
// scoreboard queue filled when each step's stimulus is driven.
module tb_exec_stage;
  import mips_pkg::*;

  typedef struct packed {
    logic [63:0] aluout;
    logic [63:0] writedata;
    logic [4:0]  writereg;
  } m_entry_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  m_entry_t sb[$];

  exec_stage_if #(.N(64), .W(32), .R(5)) bus ();

  exec_stage #(.N(64), .W(32), .R(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  // Independent reference model of the ALU.
  function automatic logic [63:0] ref_alu(input logic [3:0] op,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
    logic [31:0] t;
    logic [5:0]  s;
    logic signed [63:0] sb_val;
    s = a[5:0];
    sb_val = b;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return (a | b) & ~(a & b);
      4'd4:  return ~a & ~b;
      4'd5:  return b * (64'd1 << s);
      4'd6:  return a + ~b + 64'd1;
      4'd7:  return (a[63] != b[63]) ? {63'd0, a[63]} : {63'd0, (a < b)};
      4'd8:  return {63'd0, (a < b)};
      4'd9:  return b >> s;
      4'd10: begin t = a[31:0] + b[31:0]; return {{32{t[31]}}, t}; end
      4'd11: return 64'(sb_val >>> s);
      4'd14: begin t = a[31:0] + ~b[31:0] + 32'd1; return {{32{t[31]}}, t}; end
      4'd15: return b;
      default: return 64'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one E-stage step at the falling edge, check the combinational
  // outputs, and queue what the M side must show after the next edge.
  task automatic drive(input string tag, input logic [3:0] op,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] wd, input logic [4:0] wr,
                       input logic rst);
    m_entry_t e;
    logic [63:0] y;
    @(negedge clk);
    reset           = rst;
    bus.alucontrolE = op;
    bus.srcaE       = a;
    bus.srcbE       = b;
    bus.writedataE  = wd;
    bus.writeregE   = wr;
    y = ref_alu(op, a, b);
    #1;
    check({tag, " aluoutE"}, bus.aluoutE, y);
    check({tag, " zero"}, {63'd0, bus.zero}, {63'd0, (y == 64'd0)});
    e.aluout    = rst ? 64'd0 : y;
    e.writedata = rst ? 64'd0 : wd;
    e.writereg  = rst ? 5'd0 : wr;
    sb.push_back(e);
  endtask

  task automatic tick(input string tag);
    m_entry_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, " aluoutM"}, bus.aluoutM, e.aluout);
      check({tag, " writedataM"}, bus.writedataM, e.writedata);
      check({tag, " writeregM"}, {59'd0, bus.writeregM}, {59'd0, e.writereg});
    end
  endtask

  task automatic branch(input logic [31:0] pc, input logic [31:0] off,
                        input logic [31:0] exp);
    bus.pcE  = pc;
    bus.offE = off;
    #1;
    check("pcbranch", {32'd0, bus.pcbranch}, {32'd0, exp});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset           = 1'b1;
    bus.srcaE       = '0;
    bus.srcbE       = '0;
    bus.alucontrolE = '0;
    bus.writedataE  = '0;
    bus.writeregE   = '0;
    bus.pcE         = '0;
    bus.offE        = '0;

    // Reset state of the E->M register.
    drive("rst", ALU_ADD, 64'h0, 64'h0, 64'h0, 5'd0, 1'b1);
    tick("rst");

    // ADD wraps to zero.
    drive("add_wrap", ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h1111, 5'd1, 1'b0);
    check("add_wrap const", bus.aluoutE, 64'd0);
    check("add_wrap zero", {63'd0, bus.zero}, 64'd1);
    tick("add_wrap");

    // SUB wraps below zero.
    drive("sub_wrap", ALU_SUB, 64'd0, 64'd1, 64'h2222, 5'd2, 1'b0);
    check("sub_wrap const", bus.aluoutE, 64'hFFFF_FFFF_FFFF_FFFF);
    tick("sub_wrap");

    // Signed vs unsigned compare of -2 and 3.
    drive("slt", ALU_SLT, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'h3333, 5'd3, 1'b0);
    check("slt const", bus.aluoutE, 64'd1);
    tick("slt");
    drive("sltu", ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'h4444, 5'd4, 1'b0);
    check("sltu const", bus.aluoutE, 64'd0);
    tick("sltu");

    // Undefined opcodes give zero.
    drive("op1100", 4'b1100, 64'h1234, 64'h5678, 64'h5555, 5'd5, 1'b0);
    check("op1100 const", bus.aluoutE, 64'd0);
    check("op1100 zero", {63'd0, bus.zero}, 64'd1);
    tick("op1100");
    drive("op1101", 4'b1101, 64'hFF, 64'hFF, 64'h6, 5'd6, 1'b0);
    tick("op1101");

    // 32-bit ops and shifts.
    drive("add32", ALU_ADD32, 64'h7FFF_FFFF, 64'd1, 64'h7, 5'd7, 1'b0);
    check("add32 const", bus.aluoutE, 64'hFFFF_FFFF_8000_0000);
    tick("add32");
    drive("sub32", ALU_SUB32, 64'hAAAA_0000_0000_0000, 64'd1, 64'h8, 5'd8, 1'b0);
    check("sub32 const", bus.aluoutE, 64'hFFFF_FFFF_FFFF_FFFF);
    tick("sub32");
    drive("sra", ALU_SRA, 64'd4, 64'h8000_0000_0000_0000, 64'h9, 5'd9, 1'b0);
    check("sra const", bus.aluoutE, 64'hF800_0000_0000_0000);
    tick("sra");
    drive("srl", ALU_SRL, 64'd4, 64'h8000_0000_0000_0000, 64'hA, 5'd10, 1'b0);
    check("srl const", bus.aluoutE, 64'h0800_0000_0000_0000);
    tick("srl");
    drive("sll64", ALU_SLL, 64'd64, 64'hDEAD_BEEF_0000_0001, 64'hB, 5'd11, 1'b0);
    check("sll64 const", bus.aluoutE, 64'hDEAD_BEEF_0000_0001);
    tick("sll64");

    // Three back-to-back logic ops; destination $31 included.
    drive("and", ALU_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hC0DE, 5'd31, 1'b0);
    tick("and");
    drive("or", ALU_OR, 64'h0000_0000_0000_00F0, 64'h0F, 64'hBEEF, 5'd12, 1'b0);
    tick("or");
    drive("xor", ALU_XOR, 64'hFFFF_0000_FFFF_0000, 64'hFF00_FF00_FF00_FF00, 64'hCAFE, 5'd13, 1'b0);
    tick("xor");
    drive("nor", ALU_NOR, 64'h0, 64'h0, 64'h1, 5'd14, 1'b0);
    check("nor const", bus.aluoutE, 64'hFFFF_FFFF_FFFF_FFFF);
    tick("nor");
    drive("passb", ALU_PASSB, 64'h1, 64'h0000_0000_1234_0000, 64'h2, 5'd15, 1'b0);
    tick("passb");

    // Branch-target adder wrap cases.
    branch(32'h0040_0010, 32'hFFFF_FFF0, 32'h0040_0000);
    branch(32'hFFFF_FFFC, 32'd8, 32'h0000_0004);

    // Mid-stream reset with live inputs, then recovery on the next edge.
    drive("midrst", ALU_ADD, 64'd5, 64'd7, 64'hFACE, 5'd20, 1'b1);
    check("midrst aluoutE const", bus.aluoutE, 64'd12);
    tick("midrst");
    drive("post_rst", ALU_SUB, 64'd100, 64'd1, 64'hF00D, 5'd21, 1'b0);
    tick("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
